// File: rtl/gray_pkg.sv
// Shared definitions for the RGB-to-luma sequencer: luma coefficients,
// accumulator width, FSM state encoding and the output rounding helper.
// GRAY_CEIL_EN selects ceiling rounding of the luma result; truncation otherwise.
package gray_pkg;

   localparam int ACC_W = 40;

   // Unsigned 0.32 fractions; they sum to 2^32+1 so white maps to 255.
   localparam logic [31:0] C_R = 32'h4C8B4396;
   localparam logic [31:0] C_G = 32'h9645A1CB;
   localparam logic [31:0] C_B = 32'h1D2F1AA0;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      MUL_R = 3'd1,
      MUL_G = 3'd2,
      MUL_B = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Integer part of the accumulator, optionally rounded up and saturated.
   function automatic logic [7:0] luma_round(input logic [ACC_W-1:0] acc);
`ifdef GRAY_CEIL_EN
      logic [ACC_W:0] sum;
      sum = {1'b0, acc} + {1'b0, 40'h00FFFFFFFF};
      return sum[ACC_W] ? 8'hFF : sum[ACC_W-1:ACC_W-8];
`else
      return acc[ACC_W-1:ACC_W-8];
`endif
   endfunction

endpackage

// File: rtl/gray_mac.sv
// Shared 8x32 multiplier with a 40-bit accumulator. clr_i loads the product
// instead of adding it, starting a new pixel. acc_d_o exposes the value the
// accumulator takes at the next edge so the controller can register the result
// in the same cycle the last term is added.
module gray_mac
   import gray_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic [7:0]       a_i,
   input  logic [31:0]      coef_i,
   output logic [ACC_W-1:0] acc_o,
   output logic [ACC_W-1:0] acc_d_o
);

   logic [ACC_W-1:0] prod;
   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;

   // 8x32 product always fits in 40 bits; three terms cannot overflow either.
   assign prod = {32'd0, a_i} * {8'd0, coef_i};

   // Next accumulator value: hold, load or accumulate.
   always_comb begin
      acc_d = acc_q;
      if (en_i) begin
         acc_d = clr_i ? prod : (acc_q + prod);
      end
   end

   // Accumulator register, cleared by synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o   = acc_q;
   assign acc_d_o = acc_d;

endmodule

// File: rtl/gray_seq_ctrl.sv
// Streaming RGB-to-luma controller. One pixel is accepted in IDLE, the shared
// multiplier is stepped through R, G and B, and the result is held in DONE
// until the downstream accepts it. Keeps a per-frame pixel counter and flags
// the last pixel of each frame on oEOF.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; a producer holds its data stable while valid is high and ready is low.
// Build option: GRAY_CEIL_EN selects ceiling rounding of oGray (see gray_pkg).
module gray_seq_ctrl
   import gray_pkg::*;
#(
   parameter int FRAME_PIXELS = 307200,
   parameter int CNT_W        = 19
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic [7:0]       iR,
   input  logic [7:0]       iG,
   input  logic [7:0]       iB,
   input  logic             iValid,
   output logic             oReady,
   output logic [7:0]       oGray,
   output logic             oEOF,
   output logic             oValid,
   input  logic             iReady,
   output logic [CNT_W-1:0] oPixCnt,
   output logic [2:0]       oDbgState
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

   state_t           state_q;
   logic [7:0]       r_q, g_q, b_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ready_q;
   logic             valid_q;
   logic             eof_q;
   logic [7:0]       gray_q;

   logic [7:0]       mul_a;
   logic [31:0]      mul_c;
   logic             mul_en;
   logic             mul_clr;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_d;

   // Multiplier operand select, driven purely by the current state.
   always_comb begin
      mul_a   = 8'd0;
      mul_c   = 32'd0;
      mul_en  = 1'b0;
      mul_clr = 1'b0;
      case (state_q)
         MUL_R: begin
            mul_a   = r_q;
            mul_c   = C_R;
            mul_en  = 1'b1;
            mul_clr = 1'b1;
         end
         MUL_G: begin
            mul_a  = g_q;
            mul_c  = C_G;
            mul_en = 1'b1;
         end
         MUL_B: begin
            mul_a  = b_q;
            mul_c  = C_B;
            mul_en = 1'b1;
         end
         default: begin
            mul_a   = 8'd0;
            mul_c   = 32'd0;
            mul_en  = 1'b0;
            mul_clr = 1'b0;
         end
      endcase
   end

   gray_mac u_mac (
      .clk_i   (iCLK),
      .rst_i   (iRST),
      .en_i    (mul_en),
      .clr_i   (mul_clr),
      .a_i     (mul_a),
      .coef_i  (mul_c),
      .acc_o   (acc),
      .acc_d_o (acc_d)
   );

   // Sequencer FSM with registered handshake outputs, result and pixel counter.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q <= IDLE;
         r_q     <= 8'd0;
         g_q     <= 8'd0;
         b_q     <= 8'd0;
         cnt_q   <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         eof_q   <= 1'b0;
         gray_q  <= 8'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (iValid && ready_q) begin
                  r_q     <= iR;
                  g_q     <= iG;
                  b_q     <= iB;
                  ready_q <= 1'b0;
                  state_q <= MUL_R;
               end
            end
            MUL_R: state_q <= MUL_G;
            MUL_G: state_q <= MUL_B;
            MUL_B: begin
               // Last term lands in acc this edge; capture the rounded result.
               gray_q  <= luma_round(acc_d);
               eof_q   <= (cnt_q == LAST_IDX);
               valid_q <= 1'b1;
               state_q <= DONE;
            end
            DONE: begin
               if (iReady) begin
                  valid_q <= 1'b0;
                  eof_q   <= 1'b0;
                  ready_q <= 1'b1;
                  cnt_q   <= (cnt_q == LAST_IDX) ? '0 : (cnt_q + CNT_W'(1));
                  state_q <= IDLE;
               end
            end
            default: begin
               valid_q <= 1'b0;
               eof_q   <= 1'b0;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign oReady    = ready_q;
   assign oValid    = valid_q;
   assign oGray     = gray_q;
   assign oEOF      = eof_q;
   assign oPixCnt   = cnt_q;
   assign oDbgState = state_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Directed bench for gray_seq_ctrl with a 4-pixel frame. Expected luma values
// are hand-computed per build (GRAY_CEIL_EN selects the rounded table); a
// negedge monitor also scores every output handshake against a reference model.
module tb_gray_seq_ctrl;
   import gray_pkg::*;

   localparam int FP = 4;
   localparam int CW = 3;

   logic          iCLK;
   logic          iRST;
   logic [7:0]    iR, iG, iB;
   logic          iValid;
   logic          oReady;
   logic [7:0]    oGray;
   logic          oEOF;
   logic          oValid;
   logic          iReady;
   logic [CW-1:0] oPixCnt;
   logic [2:0]    oDbgState;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int out_cnt = 0;

   logic [7:0]    exp_q[$];
   logic [CW-1:0] exp_cnt = '0;
   logic          stream_on = 1'b0;
   logic          have_last = 1'b0;
   int            last_cyc  = 0;

   gray_seq_ctrl #(.FRAME_PIXELS(FP), .CNT_W(CW)) dut (
      .iCLK      (iCLK),
      .iRST      (iRST),
      .iR        (iR),
      .iG        (iG),
      .iB        (iB),
      .iValid    (iValid),
      .oReady    (oReady),
      .oGray     (oGray),
      .oEOF      (oEOF),
      .oValid    (oValid),
      .iReady    (iReady),
      .oPixCnt   (oPixCnt),
      .oDbgState (oDbgState)
   );

   // ---------------- clock / cycle counter ----------------
   initial begin
      iCLK = 1'b0;
      forever #5 iCLK = ~iCLK;
   end

   always @(posedge iCLK) cyc <= cyc + 1;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ref_gray(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      logic [40:0] s;
      s = 41'(r) * 41'(C_R) + 41'(g) * 41'(C_G) + 41'(b) * 41'(C_B);
`ifdef GRAY_CEIL_EN
      s = s + 41'h00FFFFFFFF;
      if (s[40:32] > 9'd255) return 8'd255;
`endif
      return s[39:32];
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge iCLK) begin
      if (iRST) begin
         exp_q.delete();
         exp_cnt = '0;
      end else begin
         if (oValid && iReady) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_output", 32'(oGray), 32'hFFFF_FFFF);
            end else begin
               check("sb_gray", 32'(oGray), 32'(exp_q.pop_front()));
               check("sb_pixcnt", 32'(oPixCnt), 32'(exp_cnt));
               check("sb_eof", 32'(oEOF), 32'(exp_cnt == CW'(FP - 1)));
            end
            if (stream_on && have_last) check("sb_spacing", 32'(cyc - last_cyc), 32'd5);
            have_last = 1'b1;
            last_cyc  = cyc;
            out_cnt++;
            exp_cnt = (exp_cnt == CW'(FP - 1)) ? '0 : exp_cnt + 1'b1;
         end
         if (iValid && oReady) exp_q.push_back(ref_gray(iR, iG, iB));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!oReady && n < 20) begin
         tick();
         n++;
      end
      if (!oReady) check(tag, 32'(oReady), 32'd1);
   endtask

   // One pixel with iReady high; returns observed latency, count and EOF.
   task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                             input logic [7:0] exp_gray, output int lat,
                             output logic [CW-1:0] cnt_obs, output logic eof_obs);
      wait_ready("tmo_ready");
      iR = r; iG = g; iB = b; iValid = 1'b1;
      tick();
      iValid = 1'b0;
      iR = 8'($urandom_range(0, 255));
      iG = 8'($urandom_range(0, 255));
      iB = 8'($urandom_range(0, 255));
      lat = 1;
      while (!oValid && lat < 20) begin
         tick();
         lat++;
      end
      check("pix_gray", 32'(oGray), 32'(exp_gray));
      cnt_obs = oPixCnt;
      eof_obs = oEOF;
      tick();
      check("pix_valid_drop", 32'(oValid), 32'd0);
   endtask

   // ---------------- directed tables ----------------
   logic [7:0]    t_r   [9] = '{8'd255, 8'd0,   8'd0,   8'd255, 8'd0, 8'd100, 8'd10, 8'd128, 8'd200};
   logic [7:0]    t_g   [9] = '{8'd0,   8'd255, 8'd0,   8'd255, 8'd0, 8'd100, 8'd20, 8'd64,  8'd50};
   logic [7:0]    t_b   [9] = '{8'd0,   8'd0,   8'd255, 8'd255, 8'd0, 8'd100, 8'd30, 8'd32,  8'd0};
`ifdef GRAY_CEIL_EN
   logic [7:0]    t_y   [9] = '{8'd77,  8'd150, 8'd30,  8'd255, 8'd0, 8'd101, 8'd19, 8'd80,  8'd90};
`else
   logic [7:0]    t_y   [9] = '{8'd76,  8'd149, 8'd29,  8'd255, 8'd0, 8'd100, 8'd18, 8'd79,  8'd89};
`endif
   logic [CW-1:0] t_cnt [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
   logic          t_eof [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   // ---------------- main sequence ----------------
   initial begin
      int            lat;
      logic [CW-1:0] c_obs;
      logic          e_obs;
      logic [7:0]    bp_exp;
      int            n;
      int            seen;
      int            start_outs;

      iRST = 1'b1; iValid = 1'b0; iReady = 1'b1;
      iR = 8'd0; iG = 8'd0; iB = 8'd0;
      repeat (3) tick();
      iRST = 1'b0;
      tick();
      check("rst_valid", 32'(oValid), 32'd0);
      check("rst_ready", 32'(oReady), 32'd1);
      check("rst_pixcnt", 32'(oPixCnt), 32'd0);
      check("rst_eof", 32'(oEOF), 32'd0);
      check("rst_gray", 32'(oGray), 32'd0);

      // Single pixels doubling as the frame-wrap sequence.
      for (int i = 0; i < 9; i++) begin
         send_pixel(t_r[i], t_g[i], t_b[i], t_y[i], lat, c_obs, e_obs);
         check("pix_latency", 32'(lat), 32'd4);
         check("wrap_pixcnt", 32'(c_obs), 32'(t_cnt[i]));
         check("wrap_eof", 32'(e_obs), 32'(t_eof[i]));
      end

      // Backpressure: result held for 10 cycles while inputs toggle.
`ifdef GRAY_CEIL_EN
      bp_exp = 8'd90;
`else
      bp_exp = 8'd89;
`endif
      wait_ready("tmo_bp_ready");
      iReady = 1'b0;
      iR = 8'd200; iG = 8'd50; iB = 8'd0; iValid = 1'b1;
      tick();
      n = 0;
      while (!oValid && n < 20) begin
         iR = 8'($urandom_range(0, 255));
         tick();
         n++;
      end
      check("bp_latency", 32'(n + 1), 32'd4);
      for (int k = 0; k < 10; k++) begin
         check("bp_valid", 32'(oValid), 32'd1);
         check("bp_ready", 32'(oReady), 32'd0);
         check("bp_gray", 32'(oGray), 32'(bp_exp));
         check("bp_pixcnt", 32'(oPixCnt), 32'(exp_cnt));
         iR = 8'($urandom_range(0, 255));
         iG = 8'($urandom_range(0, 255));
         iB = 8'($urandom_range(0, 255));
         tick();
      end
      iR = 8'd0; iG = 8'd255; iB = 8'd0;
      iReady = 1'b1;
      tick();
      check("bp_release_valid", 32'(oValid), 32'd0);
      check("bp_release_ready", 32'(oReady), 32'd1);
      tick();
      check("bp_next_accepted", 32'(oDbgState), 32'(MUL_R));
      iValid = 1'b0;
      n = 0;
      while (!oValid && n < 20) begin
         tick();
         n++;
      end
`ifdef GRAY_CEIL_EN
      check("bp_next_gray", 32'(oGray), 32'd150);
`else
      check("bp_next_gray", 32'(oGray), 32'd149);
`endif
      tick();

      // Reset while in MUL_G drops the pixel.
      wait_ready("tmo_rst_ready");
      iR = 8'd255; iG = 8'd255; iB = 8'd255; iValid = 1'b1;
      tick();
      iValid = 1'b0;
      tick();
      check("rst_mid_state", 32'(oDbgState), 32'(MUL_G));
      iRST = 1'b1;
      tick();
      iRST = 1'b0;
      check("rst_mid_valid", 32'(oValid), 32'd0);
      check("rst_mid_ready", 32'(oReady), 32'd1);
      check("rst_mid_pixcnt", 32'(oPixCnt), 32'd0);
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         if (oValid) seen++;
         tick();
      end
      check("rst_mid_dropped", 32'(seen), 32'd0);

      // Continuous iValid with random pixels, scored by the monitor.
      stream_on  = 1'b1;
      have_last  = 1'b0;
      start_outs = out_cnt;
      for (int i = 0; i < 100; i++) begin
         iR = 8'($urandom_range(0, 255));
         iG = 8'($urandom_range(0, 255));
         iB = 8'($urandom_range(0, 255));
         iValid = 1'b1;
         wait_ready("tmo_stream_ready");
         tick();
      end
      iValid = 1'b0;
      n = 0;
      while (out_cnt - start_outs < 100 && n < 200) begin
         tick();
         n++;
      end
      repeat (3) tick();
      check("stream_outputs", 32'(out_cnt - start_outs), 32'd100);
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      stream_on = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global time limit.
   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
